// File: rtl/prbs31_pkg.sv
// ---------------------------------------------------------------------------
// prbs31_pkg
// Shared constants and types for the PRBS31 (x^31 + x^28 + 1) checker tile.
//   - LFSR geometry and feedback tap positions
//   - FSM state encoding (FILL / LOCKED)
//   - readout select codes for the uo_out byte mux
// ---------------------------------------------------------------------------
package prbs31_pkg;

  localparam int LFSR_W = 31;
  localparam int TAP_HI = 30;
  localparam int TAP_LO = 27;

  typedef enum logic {
    FILL   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    SEL_ERR0   = 3'd0,
    SEL_ERR1   = 3'd1,
    SEL_ERR2   = 3'd2,
    SEL_BIT0   = 3'd3,
    SEL_BIT1   = 3'd4,
    SEL_BIT2   = 3'd5,
    SEL_BIT3   = 3'd6,
    SEL_STATUS = 3'd7
  } sel_e;

endpackage

// File: rtl/prbs31_lfsr_check.sv
// ---------------------------------------------------------------------------
// prbs31_lfsr_check
// Receive-side shift register plus prediction/mismatch logic.
// The register always shifts in the received bit (self-synchronising), so a
// single corrupted bit is seen three times: on arrival and at both taps.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   shift_en     shift the register by one (a valid bit this cycle)
//   d            effective received bit (polarity already applied)
//   mismatch     d differs from the polynomial prediction (combinational)
//   reg_nonzero  register contents after this shift would be nonzero
// ---------------------------------------------------------------------------
module prbs31_lfsr_check
  import prbs31_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic shift_en,
  input  logic d,
  output logic mismatch,
  output logic reg_nonzero
);

  logic [LFSR_W-1:0] s_q;
  logic [LFSR_W-1:0] s_d;
  logic              pred;

  always_comb begin
    s_d = s_q;
    if (shift_en) begin
      s_d = {s_q[LFSR_W-2:0], d};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q <= '0;
    end else begin
      s_q <= s_d;
    end
  end

  assign pred        = s_q[TAP_HI] ^ s_q[TAP_LO];
  assign mismatch    = d ^ pred;
  // Looks at the register as it will be once d is shifted in, so the FSM can
  // decide on the very bit that completes the fill.
  assign reg_nonzero = |{s_q[LFSR_W-2:0], d};

endmodule

// File: rtl/tt_um_ronmsjsu_prbs31_checker.sv
// ---------------------------------------------------------------------------
// tt_um_ronmsjsu_prbs31_checker
// Self-synchronising PRBS31 receiver/checker on the Tiny Tapeout pin set.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   ena         tile select (ignored)
//   ui_in       [0] data, [1] bit_valid, [2] clr, [3] invert, [6:4] select
//   uo_out      registered readout byte (err_cnt / bit_cnt bytes / status)
//   uio_in      unused
//   uio_out     [0] locked, [1] err_pulse, [2] err_sticky, [3] sat
//   uio_oe      constant 8'h0F
// Handshake: a bit is consumed on every rising edge where bit_valid = 1;
// there is no back-pressure, and bit_valid = 0 cycles leave all state alone.
// ---------------------------------------------------------------------------
module tt_um_ronmsjsu_prbs31_checker
  import prbs31_pkg::*;
#(
  parameter int LOSS_THRESH = 8,
  parameter int ERR_W       = 24,
  parameter int BIT_W       = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int FILL_W = 5;
  localparam int MISS_W = $clog2(LOSS_THRESH + 1);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(LFSR_W - 1);
  localparam logic [MISS_W-1:0] MISS_LIM  = MISS_W'(LOSS_THRESH);

  // Pin decode
  logic bit_in;
  logic bit_valid;
  logic clr;
  logic invert;
  sel_e sel;
  logic d_eff;

  assign bit_in    = ui_in[0];
  assign bit_valid = ui_in[1];
  assign clr       = ui_in[2];
  assign invert    = ui_in[3];
  assign sel       = sel_e'(ui_in[6:4]);
  assign d_eff     = bit_in ^ invert;

  logic unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in, ui_in[7]};

  // State
  state_e            state_q,      state_d;
  logic [FILL_W-1:0] fill_cnt_q,   fill_cnt_d;
  logic [MISS_W-1:0] miss_cnt_q,   miss_cnt_d;
  logic [ERR_W-1:0]  err_cnt_q,    err_cnt_d;
  logic [BIT_W-1:0]  bit_cnt_q,    bit_cnt_d;
  logic              err_sticky_q, err_sticky_d;
  logic              err_pulse_q,  err_pulse_d;
  logic              sat_q,        sat_d;
  logic [7:0]        uo_out_q,     uo_out_d;

  logic mismatch;
  logic reg_nonzero;
  logic locked;
  logic [MISS_W-1:0] miss_inc;

  prbs31_lfsr_check u_lfsr (
    .clk         (clk),
    .rst_n       (rst_n),
    .shift_en    (bit_valid),
    .d           (d_eff),
    .mismatch    (mismatch),
    .reg_nonzero (reg_nonzero)
  );

  assign locked   = (state_q == LOCKED);
  assign miss_inc = miss_cnt_q + 1'b1;

  // FSM next state and counters
  always_comb begin
    state_d      = state_q;
    fill_cnt_d   = fill_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    err_cnt_d    = err_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    err_sticky_d = err_sticky_q;
    err_pulse_d  = 1'b0;
    sat_d        = sat_q;

    if (bit_valid) begin
      unique case (state_q)
        FILL: begin
          if (fill_cnt_q == FILL_LAST) begin
            // An all-zero fill is the LFSR lock-up state; refill instead.
            fill_cnt_d = '0;
            if (reg_nonzero) begin
              state_d = LOCKED;
            end
          end else begin
            fill_cnt_d = fill_cnt_q + 1'b1;
          end
        end
        LOCKED: begin
          if (!(&bit_cnt_q)) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
          if (mismatch) begin
            if (!(&err_cnt_q)) begin
              err_cnt_d = err_cnt_q + 1'b1;
            end
            err_sticky_d = 1'b1;
            err_pulse_d  = 1'b1;
            if (miss_inc == MISS_LIM) begin
              state_d    = FILL;
              fill_cnt_d = '0;
              miss_cnt_d = '0;
            end else begin
              miss_cnt_d = miss_inc;
            end
          end else begin
            miss_cnt_d = '0;
          end
        end
        default: begin
          state_d = FILL;
        end
      endcase
    end

    if ((&err_cnt_d) || (&bit_cnt_d)) begin
      sat_d = 1'b1;
    end

    // Clear takes priority over any count made on the same bit.
    if (clr) begin
      err_cnt_d    = '0;
      bit_cnt_d    = '0;
      err_sticky_d = 1'b0;
      sat_d        = 1'b0;
    end
  end

  // Readout mux works from the registered counters, giving one extra cycle
  // between a counter update and its appearance on uo_out.
  always_comb begin
    logic [31:0] err_ext;
    logic [31:0] bit_ext;
    err_ext  = 32'(err_cnt_q);
    bit_ext  = 32'(bit_cnt_q);
    uo_out_d = 8'h00;
    unique case (sel)
      SEL_ERR0:   uo_out_d = err_ext[7:0];
      SEL_ERR1:   uo_out_d = err_ext[15:8];
      SEL_ERR2:   uo_out_d = err_ext[23:16];
      SEL_BIT0:   uo_out_d = bit_ext[7:0];
      SEL_BIT1:   uo_out_d = bit_ext[15:8];
      SEL_BIT2:   uo_out_d = bit_ext[23:16];
      SEL_BIT3:   uo_out_d = bit_ext[31:24];
      SEL_STATUS: uo_out_d = {4'b0000, sat_q, err_sticky_q, locked,
                              (state_q == FILL)};
      default:    uo_out_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= FILL;
      fill_cnt_q   <= '0;
      miss_cnt_q   <= '0;
      err_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      err_sticky_q <= 1'b0;
      err_pulse_q  <= 1'b0;
      sat_q        <= 1'b0;
      uo_out_q     <= 8'h00;
    end else begin
      state_q      <= state_d;
      fill_cnt_q   <= fill_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      err_cnt_q    <= err_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      err_sticky_q <= err_sticky_d;
      err_pulse_q  <= err_pulse_d;
      sat_q        <= sat_d;
      uo_out_q     <= uo_out_d;
    end
  end

  assign uo_out  = uo_out_q;
  assign uio_out = {4'b0000, sat_q, err_sticky_q, err_pulse_q, locked};
  assign uio_oe  = 8'h0F;

endmodule

// File: doc/tt_um_ronmsjsu_prbs31_checker.md
# tt_um_ronmsjsu_prbs31_checker

Self-synchronising PRBS31 (x^31 + x^28 + 1) receiver/checker. It is the far-end companion to the team's PRBS31 generator tile. It takes a serial bit stream with a per-bit valid strobe, seeds itself from the incoming data, and then verifies every later bit against the polynomial. It counts errors and received bits, and exposes lock status, an error pulse, and a byte-selectable readout on the standard Tiny Tapeout pin set.

## Interface
- LOSS_THRESH, 8: consecutive mismatches in LOCKED that force a relock.
- ERR_W, 24: error-counter width; the counter saturates at its maximum value.
- BIT_W, 32: received-bit-counter width; the counter saturates at its maximum value.
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- ena  in  1  tile select; ignored, and the design stays clocked.
- ui_in  in  8  [0] serial data; [1] bit_valid; [2] clr (synchronous counter clear); [3] invert (data polarity); [6:4] readout select; [7] unused.
- uo_out  out  8  registered readout byte.
- uio_in  in  8  unused.
- uio_out  out  8  [0] locked; [1] err_pulse; [2] err_sticky; [3] sat (either counter saturated); [7:4] 0.
- uio_oe  out  8  constant 8'h0F.

## Operation
- Effective bit: d = ui_in[0] ^ invert. It is sampled only on cycles where bit_valid = 1. Cycles with bit_valid = 0 change no state.
- Shift register s[30:0]. Each valid bit shifts in as s <= {s[29:0], d}. The register always shifts the received bit, never the predicted one.
- Predicted bit: p = s[30] ^ s[27]. A mismatch is d != p.
- FSM has two states, FILL and LOCKED.
  - FILL: fill_cnt counts valid bits, 0..30. When the 31st valid bit arrives, check the updated register. If it is nonzero, go to LOCKED. If it is all zero, stay in FILL and set fill_cnt to 0. No comparison happens in FILL.
  - LOCKED, valid bit with a match: miss_cnt <= 0.
  - LOCKED, valid bit with a mismatch: err_cnt += 1, err_sticky <= 1, err_pulse for one cycle, miss_cnt += 1.
  - LOCKED, loss of lock: when miss_cnt reaches LOSS_THRESH (on that same bit), go to FILL with fill_cnt = 0 and miss_cnt = 0. The erroring bit that caused the loss still counts.
- bit_cnt increments on every valid bit in LOCKED only.
- clr:
  - Zeroes err_cnt, bit_cnt, err_sticky and sat.
  - Does not touch the FSM, the shift register, fill_cnt or miss_cnt.
  - When clr and a counted event occur in the same cycle, clr wins and the counters read 0.
- Saturation: the counters stick at all-ones and sat = 1 until clr or reset.
- Readout select ui_in[6:4]:
  - 0..2: err_cnt bytes 0..2 (LSB first).
  - 3..6: bit_cnt bytes 0..3.
  - 7: status {4'b0, sat, err_sticky, locked, state==FILL}.
- A single flipped bit in a clean locked stream produces exactly 3 mismatches: once on arrival, once when it reaches tap 27, and once at tap 30.

## Timing
- Reset values:
  - uo_out = 0 and uio_out = 0.
  - State FILL; s, fill_cnt, miss_cnt, err_cnt, bit_cnt, err_sticky and sat all 0.
- locked rises in the cycle after the 31st valid bit is sampled.
- err_pulse is high exactly 1 cycle, in the cycle after the mismatching bit is sampled. It stays high through back-to-back mismatching valid bits.
- Counters and sticky bits update in the cycle after the sample. uo_out reflects the new value one further cycle later, giving 2-cycle readout latency from the bit.
- A change on the select pins appears on uo_out after 1 cycle.
- Reset asserted mid-stream overrides everything on that edge. It must be held for at least 1 clk edge.
- bit_valid may be asserted every cycle; there is no minimum gap.

## Structure
- Package prbs31_pkg holds:
  - tap constants TAP_HI = 30 and TAP_LO = 27;
  - the state enum {FILL, LOCKED};
  - readout select codes SEL_ERR0..SEL_BIT3 and SEL_STATUS.
- One sub-module, prbs31_lfsr_check. It contains the shift register plus the prediction/mismatch logic, with inputs shift_en and d and outputs mismatch and reg_nonzero.
- The top level holds the FSM, the counters, the readout mux and the pin mapping.

## Test plan
- Clean lock:
  - Stimulus: generator stream, seed 0x7FFFFFFF, bit_valid every cycle for 1000 bits.
  - Required response: locked = 1 from the cycle after bit 31; err_cnt = 0; bit_cnt = 969; err_sticky = 0.
- Single error:
  - Stimulus: flip one bit at position 500 of a clean 1000-bit stream.
  - Required response: err_cnt = 3; locked stays 1; err_pulse fires 3 times; err_sticky = 1.
- Loss of lock:
  - Stimulus: after lock, feed random non-PRBS data.
  - Required response: locked drops within a few bits once 8 consecutive mismatches occur; state returns to FILL. Then resume a clean stream and require relock 31 valid bits later.
- All-zero stream:
  - Stimulus: 200 valid zeros.
  - Required response: locked never asserts; status byte reads 8'h01.
- Polarity and gaps:
  - Stimulus: inverted stream with invert = 1 and bit_valid toggling 1/0.
  - Required response: identical counters to the clean-lock case.
- Clear and reset:
  - Stimulus: clr together with a mismatching bit, then rst_n low mid-stream.
  - Required response: after clr, err_cnt = 0 and locked unchanged. After reset, all outputs are 0 and the state is FILL.
